// File: rtl/operand_loader.sv
// Operand front end: syncs switch byte and buttons, debounces, assembles two 16-bit operands.
// Build option OPLOAD_HOLD_EN: once all four bytes are loaded, set presses are ignored until a clear.
module operand_loader_btn #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic press
);
  logic [1:0]       sync;
  logic             lvl, lvl_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], din};
      lvl_q <= lvl;
      press <= lvl & ~lvl_q;
      // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= ~lvl;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  inp,
  input  logic        set_btn,
  input  logic        clear_btn,
  output logic [15:0] num_a,
  output logic [15:0] num_b,
  output logic [1:0]  byte_idx,
  output logic        operands_valid,
  output logic        load_pulse
);
  typedef enum logic [2:0] {LD_A_LO, LD_A_HI, LD_B_LO, LD_B_HI, DONE} state_t;

  state_t          state;
  logic [1:0][7:0] inp_sync;
  logic [1:0]      ev;
  logic            set_ev, clr_ev;

  operand_loader_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn [1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({clear_btn, set_btn}),
    .press(ev)
  );

  assign set_ev = ev[0];
  assign clr_ev = ev[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inp_sync <= '0;
    else        inp_sync <= {inp_sync[0], inp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LD_A_LO;
      num_a          <= '0;
      num_b          <= '0;
      byte_idx       <= 2'd0;
      operands_valid <= 1'b0;
      load_pulse     <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      // Clear has priority over a coincident set press.
      if (clr_ev) begin
        state          <= LD_A_LO;
        num_a          <= '0;
        num_b          <= '0;
        byte_idx       <= 2'd0;
        operands_valid <= 1'b0;
      end else if (set_ev) begin
        case (state)
          LD_A_LO: begin
            num_a[7:0] <= inp_sync[1];
            state      <= LD_A_HI;
            byte_idx   <= 2'd1;
            load_pulse <= 1'b1;
          end
          LD_A_HI: begin
            num_a[15:8] <= inp_sync[1];
            state       <= LD_B_LO;
            byte_idx    <= 2'd2;
            load_pulse  <= 1'b1;
          end
          LD_B_LO: begin
            num_b[7:0] <= inp_sync[1];
            state      <= LD_B_HI;
            byte_idx   <= 2'd3;
            load_pulse <= 1'b1;
          end
          LD_B_HI: begin
            num_b[15:8]    <= inp_sync[1];
            state          <= DONE;
            byte_idx       <= 2'd0;
            operands_valid <= 1'b1;
            load_pulse     <= 1'b1;
          end
          DONE: begin
`ifdef OPLOAD_HOLD_EN
            state <= DONE;
`else
            // Restart: new A_LO, the rest is kept until overwritten.
            num_a[7:0]     <= inp_sync[1];
            state          <= LD_A_HI;
            byte_idx       <= 2'd1;
            operands_valid <= 1'b0;
            load_pulse     <= 1'b1;
`endif
          end
          default: state <= LD_A_LO;
        endcase
      end
    end
  end
endmodule
